// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch port.
//   FETCH_ADDR_W / FETCH_INSTR_W : default PC and instruction widths
//   fetch_entry_t                : {instr, pc, fault} as presented on iss_*
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
    logic                     fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- synchronous FIFO used for both the PC and response queues.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear (wins over push/pop)
//   push, push_data     : write; accepted when not full or when popping
//   pop, head_data      : read; head_data is the oldest entry
//   full, empty, count  : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    rd_en    = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_port.sv
// instr_fetch_port -- credit-limited instruction fetch between instr_loader
// and an in-order memory port.
//   req_valid/req_ready/req_pc             : PC requests from instr_loader
//   flush                                  : discard in-flight and buffered fetches
//   mem_req_valid/mem_req_ready/mem_req_addr : memory read request
//   mem_rsp_valid/mem_rsp_data/mem_rsp_err : in-order memory responses
//   iss_valid/iss_ready/iss_instr/iss_pc/iss_fault : fetched instructions out
// Build option: INSTR_FETCH_PORT_ALIGN_CHK_EN -- misaligned PCs are answered
// locally with a fault entry instead of being sent to memory.
module instr_fetch_port
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned INSTR_W    = FETCH_INSTR_W,
  parameter int unsigned MAX_OUTSTD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_pc,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  input  logic               mem_rsp_err,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [INSTR_W-1:0] iss_instr,
  output logic [ADDR_W-1:0]  iss_pc,
  output logic               iss_fault
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTD + 1);
  localparam int unsigned ENT_W = INSTR_W + ADDR_W + 1;

  // inflight_q counts every memory request without a response yet, including
  // the ones that will be dropped; drop_cnt_q is that dropped subset.
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  rsp_count, pc_count;
  logic [CNT_W:0]    credit;
  logic              rsp_full, rsp_empty, pc_full, pc_empty;
  logic [ADDR_W-1:0] pc_head;
  logic [ENT_W-1:0]  rsp_push_data, rsp_head;
  logic              issuable, mis_req, mis_fire, mem_fire;
  logic              rsp_seen, rsp_live, iss_fire;
  logic              fifo_status_unused;

  always_comb begin
    credit   = {1'b0, inflight_q} + {1'b0, rsp_count};
    // rst_n gate keeps the handshakes low while reset is held.
    issuable = rst_n && !flush && (credit < (CNT_W + 1)'(MAX_OUTSTD));
`ifdef INSTR_FETCH_PORT_ALIGN_CHK_EN
    mis_req  = (req_pc[1:0] != 2'b00);
`else
    mis_req  = 1'b0;
`endif
    mem_req_valid = req_valid && issuable && !mis_req;
    mem_req_addr  = req_pc;
    // A misaligned PC waits for memory to go idle so its fault entry cannot
    // overtake older fetches in the response queue.
    req_ready     = mis_req ? (issuable && (inflight_q == '0))
                            : (mem_req_ready && issuable);
    mis_fire      = req_valid && req_ready && mis_req;
    mem_fire      = mem_req_valid && mem_req_ready;

    rsp_seen = mem_rsp_valid && (inflight_q != '0);
    rsp_live = rsp_seen && (drop_cnt_q == '0) && !pc_empty && !flush;

    rsp_push_data = mis_fire ? {{INSTR_W{1'b0}}, req_pc, 1'b1}
                             : {mem_rsp_data, pc_head, mem_rsp_err};

    iss_valid = !rsp_empty;
    iss_fire  = iss_valid && iss_ready;
    {iss_instr, iss_pc, iss_fault} = rsp_empty ? '0 : rsp_head;

    inflight_d = inflight_q + CNT_W'(mem_fire) - CNT_W'(rsp_seen);
    drop_cnt_d = drop_cnt_q;
    // No request can fire during flush, so everything still outstanding
    // after this cycle's response becomes a drop.
    if (flush) begin
      drop_cnt_d = inflight_q - CNT_W'(rsp_seen);
    end else if (rsp_seen && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTD)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (mem_fire),
    .push_data (req_pc),
    .pop       (rsp_live),
    .head_data (pc_head),
    .full      (pc_full),
    .empty     (pc_empty),
    .count     (pc_count)
  );

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (MAX_OUTSTD)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rsp_live || mis_fire),
    .push_data (rsp_push_data),
    .pop       (iss_fire),
    .head_data (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  // Credit accounting already bounds both queues; their full flags and the
  // PC count carry no extra information here.
  assign fifo_status_unused = ^{pc_full, pc_count, rsp_full};

endmodule

// File: doc/instr_fetch_port.md
INSTR_FETCH_PORT -- requirements
Module: instr_fetch_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter MAX_OUTSTD, default 2, the maximum number of credits (issued-but-not-consumed entries); legal range 1..4.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  PC request from instr_loader
- req_ready  out  1  request accepted
- req_pc  in  ADDR_W  requested PC
- flush  in  1  discard all in-flight and buffered fetches
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read address
- mem_rsp_valid  in  1  memory response, always accepted, in order
- mem_rsp_data  in  INSTR_W  fetched word
- mem_rsp_err  in  1  bus error
- iss_valid  out  1  instruction available to instr_loader
- iss_ready  in  1  instr_loader consumes
- iss_instr  out  INSTR_W  instruction
- iss_pc  out  ADDR_W  PC of iss_instr
- iss_fault  out  1  fetch fault for iss_pc
REQ-005 SHALL use the single clock clk and the asynchronous active-low reset rst_n.

Function
REQ-006 SHALL compute credit = inflight + rsp-FIFO occupancy; a request SHALL be issuable only when credit < MAX_OUTSTD and flush=0.
REQ-007 SHALL drive mem_req_valid = req_valid & issuable, mem_req_addr = req_pc, and req_ready = mem_req_ready & issuable, all combinationally, so a request passes to memory in the same cycle.
REQ-008 SHALL push req_pc into a PC FIFO of depth MAX_OUTSTD on each mem_req handshake.
REQ-009 SHALL, on mem_rsp_valid with drop_cnt=0, pop the PC FIFO and push {data, pc, err} into the rsp FIFO (depth MAX_OUTSTD), visible on iss_* the next cycle at the earliest.
REQ-010 SHALL drive iss_valid = rsp FIFO not empty; iss_instr/iss_pc/iss_fault SHALL be the FIFO head and SHALL hold stable while iss_valid & !iss_ready.
REQ-011 SHALL pop the rsp FIFO on iss_valid & iss_ready; a pop and a push in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-012 SHALL, on flush, empty the rsp FIFO and PC FIFO, force iss_valid=0 the following cycle, and load drop_cnt with inflight minus any response arriving in that cycle.
REQ-013 SHALL discard mem responses while drop_cnt>0 and decrement drop_cnt per response; credit SHALL count drop_cnt as inflight.
REQ-014 SHALL resume accepting requests in the cycle after flush deasserts, even if drop_cnt>0.
REQ-015 SHALL treat mem_rsp_valid with inflight=0 as a protocol error and ignore it.

Reset
REQ-016 SHALL, on rst_n=0, asynchronously clear both FIFOs, inflight and drop_cnt; iss_valid=0, mem_req_valid=0, req_ready=0, iss_instr=0, iss_pc=0, iss_fault=0.
REQ-017 SHALL, if reset asserts mid-transaction, drop any later stale responses (memory is reset together).

Configuration
REQ-018 SHALL support macro INSTR_FETCH_PORT_ALIGN_CHK_EN.
- With the macro: a request with req_pc[1:0]!=0 is accepted only when inflight=0 and credit<MAX_OUTSTD; it issues no memory request and pushes {0, pc, 1} into the rsp FIFO.
- Without the macro: req_pc is passed to memory unchanged.

Structure
REQ-019 SHALL place the ADDR_W/INSTR_W defaults and the fetch_entry_t struct {instr, pc, fault} in package fetch_pkg.
REQ-020 SHALL implement both FIFOs with one parameterised sub-module, fetch_fifo (synchronous, flush input, full/empty flags).

Verification
REQ-021 SHALL cover these directed scenarios:
- Single fetch: pc=0x100, memory returns 0x00000013 after 3 cycles -> iss_valid with instr=0x13, pc=0x100, fault=0.
- Backpressure: iss_ready=0, pcs 0x0 and 0x4 -> req_ready=0 on the third request, FIFO holds both, order 0x0 then 0x4.
- Flush with 2 inflight: flush, then responses return -> both discarded, drop_cnt 2->0; new pc 0x200 returns normally.
- Simultaneous push/pop at full with MAX_OUTSTD=2 -> occupancy stays 2 and data is in order.
- mem_rsp_err=1 for pc 0x40 -> iss_fault=1, iss_pc=0x40.
- ALIGN_CHK_EN build, pc=0x102 -> no mem_req, iss_fault=1 next cycle.
